// File: rtl/potential_decay_pkg.sv
// ============================================================================
// Module      : potential_decay_pkg
// Description : Shared model codes, single-precision field constants and a
//               leading-zero helper for the potential_decay slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package potential_decay_pkg;

    localparam logic [1:0]  MODEL_LIF = 2'b00;
    localparam logic [1:0]  MODEL_IF  = 2'b01;

    localparam int          SIGN_BIT  = 31;
    localparam int          EXP_MSB   = 30;
    localparam int          EXP_LSB   = 23;
    localparam int          MAN_MSB   = 22;
    localparam logic [7:0]  EXP_BIAS  = 8'd127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;

    localparam logic [31:0] FP_ZERO   = 32'h0000_0000;

    // Returns 27 for an all-zero input.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/potential_decay_fp_sub.sv
// ============================================================================
// Module      : fp_sub
// Description : Single-precision A-B for same-sign operands with |B|<=|A| and
//               A normal. Macro POTENTIAL_DECAY_ROUND_EN selects RNE rounding,
//               otherwise the result truncates toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_sub
    import potential_decay_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [7:0]  w_ediff;
    logic [5:0]  w_sh;
    logic [53:0] w_wide;
    logic [26:0] w_mb_al;
    logic [26:0] w_diff;
    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic        w_underflow;
    logic [7:0]  w_exp_n;
    logic [7:0]  w_exp_y;
    logic [22:0] w_man_y;
    logic        w_unused;

    assign w_exp_a = a[EXP_MSB:EXP_LSB];
    assign w_exp_b = b[EXP_MSB:EXP_LSB];
    assign w_ma    = {1'b1, a[MAN_MSB:0]};
    assign w_mb    = {(w_exp_b != 8'd0), b[MAN_MSB:0]};
    assign w_ediff = w_exp_a - w_exp_b;
    assign w_sh    = (w_ediff > 8'd27) ? 6'd27 : w_ediff[5:0];

    // Lower half of the wide shift collects bits lost during alignment as sticky.
    assign w_wide  = {w_mb, 3'b000, 27'd0} >> w_sh;
    assign w_mb_al = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};

    assign w_diff      = {w_ma, 3'b000} - w_mb_al;
    assign w_lz        = lzc27(w_diff);
    assign w_norm      = w_diff << w_lz;
    assign w_underflow = (w_diff == 27'd0) || ({3'b000, w_lz} >= w_exp_a);
    assign w_exp_n     = w_exp_a - {3'b000, w_lz};

`ifdef POTENTIAL_DECAY_ROUND_EN
    logic        w_inc;
    logic [23:0] w_man_r;

    assign w_inc   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_man_r = {1'b0, w_norm[25:3]} + {23'd0, w_inc};
    assign w_exp_y = w_exp_n + {7'd0, w_man_r[23]};
    assign w_man_y = w_man_r[22:0];
    assign w_unused = b[SIGN_BIT] ^ w_norm[26];
`else
    assign w_exp_y = w_exp_n;
    assign w_man_y = w_norm[25:3];
    assign w_unused = ^{b[SIGN_BIT], w_norm[26], w_norm[2:0]};
`endif

    assign y = w_underflow ? FP_ZERO : {a[SIGN_BIT], w_exp_y, w_man_y};

endmodule

`default_nettype wire

// File: rtl/potential_decay.sv
// ============================================================================
// Module      : potential_decay
// Description : Per-neuron membrane leak: on each clear rising edge latches the
//               potential and outputs V - V*2^-d two stages later. Optional
//               macro POTENTIAL_DECAY_ROUND_EN enables RNE in the subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module potential_decay
    import potential_decay_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int FP_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              clear,
    input  logic [1:0]        model,
    input  logic [ADDR_W-1:0] neuron_address_initialization,
    input  logic [3:0]        decay_rate,
    input  logic [FP_W-1:0]   membrane_potential_initialization,
    input  logic [FP_W-1:0]   new_potential,
    output logic [FP_W-1:0]   output_potential_decay
);

    logic              r_clear_d;
    logic              r_init_done;
    logic [ADDR_W-1:0] r_neuron_address;
    logic              r_valid;
    logic [31:0]       r_v;
    logic [31:0]       r_s;
    logic              r_pass;

    logic              w_start;
    logic [31:0]       w_operand_raw;
    logic [7:0]        w_exp;
    logic [7:0]        w_d8;
    logic [31:0]       w_operand;
    logic [31:0]       w_scaled;
    logic              w_pass;
    logic [31:0]       w_sub_y;
    logic              w_unused_addr;

    assign w_start       = clear & ~r_clear_d;
    assign w_operand_raw = r_init_done ? new_potential : membrane_potential_initialization;
    assign w_exp         = w_operand_raw[EXP_MSB:EXP_LSB];
    assign w_d8          = {4'd0, decay_rate};

    // Subnormals collapse to a zero that keeps the operand's sign.
    assign w_operand = (w_exp == 8'd0) ? {w_operand_raw[SIGN_BIT], 31'd0} : w_operand_raw;
    assign w_scaled  = (w_exp <= w_d8) ? {w_operand_raw[SIGN_BIT], 31'd0}
                     : {w_operand_raw[SIGN_BIT], w_exp - w_d8, w_operand_raw[MAN_MSB:0]};

    always_comb begin
        w_pass = 1'b1;
        case (model)
            MODEL_LIF: w_pass = (decay_rate == 4'd0) || (w_exp == 8'd0) || (w_exp == EXP_MAX);
            MODEL_IF:  w_pass = 1'b1;
            default:   w_pass = 1'b1;
        endcase
    end

    fp_sub u_fp_sub (
        .a (r_v),
        .b (r_s),
        .y (w_sub_y)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_clear_d              <= 1'b0;
            r_init_done            <= 1'b0;
            r_neuron_address       <= '0;
            r_valid                <= 1'b0;
            r_v                    <= FP_ZERO;
            r_s                    <= FP_ZERO;
            r_pass                 <= 1'b0;
            output_potential_decay <= FP_ZERO;
        end else begin
            r_clear_d <= clear;
            r_valid   <= w_start;
            if (w_start) begin
                r_init_done      <= 1'b1;
                r_neuron_address <= neuron_address_initialization;
                r_v              <= w_operand;
                r_s              <= w_scaled;
                r_pass           <= w_pass;
            end
            if (r_valid) begin
                output_potential_decay <= r_pass ? r_v : w_sub_y;
            end
        end
    end

    // Address is held for the surrounding core; nothing in this block reads it.
    assign w_unused_addr = ^r_neuron_address;

endmodule

`default_nettype wire

// File: tb/tb_potential_decay.sv
// ============================================================================
// Module      : tb_potential_decay
// Description : Directed self-checking bench for potential_decay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_potential_decay;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        clear;
    logic [1:0]  model;
    logic [11:0] neuron_address_initialization;
    logic [3:0]  decay_rate;
    logic [31:0] membrane_potential_initialization;
    logic [31:0] new_potential;
    wire  [31:0] output_potential_decay;

    int n_checks = 0;
    int n_pass   = 0;

    potential_decay dut (
        .CLK                               (CLK),
        .RESET_N                           (RESET_N),
        .clear                             (clear),
        .model                             (model),
        .neuron_address_initialization     (neuron_address_initialization),
        .decay_rate                        (decay_rate),
        .membrane_potential_initialization (membrane_potential_initialization),
        .new_potential                     (new_potential),
        .output_potential_decay            (output_potential_decay)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        clear   = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // One-cycle clear pulse; sample after the second rising edge.
    task automatic strobe(input string tag, input logic [31:0] exp);
        @(negedge CLK) clear = 1'b1;
        @(negedge CLK) clear = 1'b0;
        @(posedge CLK);
        #1 check(tag, output_potential_decay, exp);
    endtask

    initial begin
        RESET_N                           = 1'b0;
        clear                             = 1'b0;
        model                             = 2'b00;
        neuron_address_initialization     = 12'h2A5;
        decay_rate                        = 4'd1;
        membrane_potential_initialization = 32'h4080_0000;
        new_potential                     = 32'h4120_0000;
        repeat (3) @(posedge CLK);
        #1 check("reset_out", output_potential_decay, 32'h0000_0000);
        @(negedge CLK) RESET_N = 1'b1;

        // 4.0, d=1: output must not move at the first edge
        @(negedge CLK) clear = 1'b1;
        @(posedge CLK);
        #1 check("lif4_latency", output_potential_decay, 32'h0000_0000);
        @(negedge CLK) clear = 1'b0;
        @(posedge CLK);
        #1 check("lif4_d1", output_potential_decay, 32'h4000_0000);
        decay_rate = 4'd5;
        repeat (4) @(posedge CLK);
        #1 check("hold_between", output_potential_decay, 32'h4000_0000);

        do_reset();
        decay_rate = 4'd2;
        membrane_potential_initialization = 32'h4120_0000;
        strobe("lif10_d2", 32'h40F0_0000);
        new_potential = 32'h40F0_0000;
        strobe("lif7p5_d2", 32'h40B4_0000);

        do_reset();
        model = 2'b01;
        decay_rate = 4'd3;
        membrane_potential_initialization = 32'h41DE_B852;
        strobe("if_pass", 32'h41DE_B852);
        model = 2'b00;
        decay_rate = 4'd0;
        new_potential = 32'h41DE_B852;
        strobe("lif_d0_pass", 32'h41DE_B852);
        model = 2'b10;
        decay_rate = 4'd1;
        new_potential = 32'h4080_0000;
        strobe("reserved_pass", 32'h4080_0000);

        do_reset();
        model = 2'b00;
        membrane_potential_initialization = 32'hC080_0000;
        strobe("neg4_d1", 32'hC000_0000);

        do_reset();
        membrane_potential_initialization = 32'h0000_0000;
        strobe("zero_init", 32'h0000_0000);

        do_reset();
        membrane_potential_initialization = 32'h0080_0000;
        strobe("min_normal", 32'h0080_0000);

        new_potential = 32'h7FC0_0000;
        strobe("nan_pass", 32'h7FC0_0000);
        new_potential = 32'hFF80_0000;
        strobe("ninf_pass", 32'hFF80_0000);

        // Held clear: operand changes mid-hold must not trigger a second decay
        new_potential = 32'h4080_0000;
        @(negedge CLK) clear = 1'b1;
        @(negedge CLK) new_potential = 32'h4120_0000;
        @(negedge CLK);
        @(negedge CLK) clear = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check("held_clear_once", output_potential_decay, 32'h4000_0000);

        // Reset while stage 2 is pending
        membrane_potential_initialization = 32'h4080_0000;
        new_potential = 32'h4120_0000;
        @(negedge CLK) clear = 1'b1;
        @(negedge CLK);
        clear   = 1'b0;
        RESET_N = 1'b0;
        #1 check("rst_mid_async", output_potential_decay, 32'h0000_0000);
        @(posedge CLK);
        #1 check("rst_mid_hold", output_potential_decay, 32'h0000_0000);
        @(negedge CLK) RESET_N = 1'b1;
        strobe("post_reset_init", 32'h4000_0000);
        strobe("second_uses_new", 32'h40A0_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
